obstacle_scheduler: RTL

- Owns the pool of on-screen obstacles for Flappy Bird (640x480): spawns, scrolls and retires up to NUM_SLOTS obstacles.
- Gap heights come from an internal LFSR.
- Driven once per video frame by frame_tick; gated by game start/crash events.
- Outputs feed the renderer and collision/score logic.

---
 rtl/obstacle_scheduler_pkg.sv | 23 ++
 rtl/obstacle_scheduler_lfsr16.sv | 24 ++
 rtl/obstacle_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/obstacle_scheduler_pkg.sv
// Shared constants and types for the Flappy Bird obstacle scheduler.
// Defaults match a 640x480 playfield.
package obstacle_scheduler_pkg;

   localparam int DEF_NUM_SLOTS    = 3;
   localparam int DEF_SCREEN_W     = 640;
   localparam int DEF_SPEED        = 2;
   localparam int DEF_SPAWN_FRAMES = 120;
   localparam int DEF_GAP_MIN      = 60;
   localparam int DEF_GAP_LOG2     = 8;
   localparam int DEF_BIRD_X       = 160;
   localparam int DEF_GAP_H        = 120;
   localparam int SCREEN_H         = 480;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FROZEN = 2'd2
   } sched_state_t;

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Non-zero seed keeps it out of the all-zero lock-up state.
module lfsr16
   import obstacle_scheduler_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] q
);

   logic [15:0] q_q;
   logic [15:0] q_d;
   logic        fb;

   assign fb  = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];
   assign q_d = {q_q[14:0], fb};
   assign q   = q_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q_q <= LFSR_SEED;
      else        q_q <= q_d;
   end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle pool: spawns, scrolls and retires obstacles once per frame.
// All outputs are registered; game state is IDLE/RUN/FROZEN.
module obstacle_scheduler
   import obstacle_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
   parameter int SCREEN_W     = DEF_SCREEN_W,
   parameter int SPEED        = DEF_SPEED,
   parameter int SPAWN_FRAMES = DEF_SPAWN_FRAMES,
   parameter int GAP_MIN      = DEF_GAP_MIN,
   parameter int GAP_LOG2     = DEF_GAP_LOG2,
   parameter int BIRD_X       = DEF_BIRD_X,
   parameter int GAP_H        = DEF_GAP_H
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic                    start,
   input  logic                    crash,
   output logic [NUM_SLOTS-1:0]    valid,
   output logic [10*NUM_SLOTS-1:0] x_flat,
   output logic [9*NUM_SLOTS-1:0]  gap_top_flat,
   output logic                    running,
   output logic                    score_pulse,
   output logic                    spawn_drop
);

   localparam int CNT_W = $clog2(SPAWN_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_FRAMES - 1);
   localparam logic [9:0] X_SPEED = 10'(SPEED);
   localparam logic [9:0] X_BIRD  = 10'(BIRD_X);
   localparam logic [9:0] X_SPAWN = 10'(SCREEN_W);
   localparam logic [8:0] G_RESET = 9'(GAP_MIN);

   if (GAP_MIN + (1 << GAP_LOG2) - 1 > SCREEN_H - 1 - GAP_H) begin : g_gap_chk
      $error("obstacle_scheduler: gap range exceeds screen height");
   end

   sched_state_t         state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 score_q, score_d;
   logic                 drop_q, drop_d;
   logic                 clear;
   logic                 tick_run;
   logic                 spawn_now;
   logic [NUM_SLOTS-1:0] free;
   logic [NUM_SLOTS-1:0] sel;
   logic [NUM_SLOTS-1:0] hit;
   logic [15:0]          lfsr;
   logic [8:0]           gap_new;
   logic                 unused_lfsr;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr)
   );

   assign unused_lfsr = ^lfsr;
   assign gap_new     = G_RESET + 9'(lfsr[GAP_LOG2-1:0]);

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      unique case (state_q)
         IDLE, FROZEN: begin
            if (start) begin
               state_d = RUN;
               clear   = 1'b1;
            end
         end
         RUN: begin
            if (crash) state_d = FROZEN;
         end
         default: state_d = IDLE;
      endcase
   end

   // crash outranks a coincident frame_tick
   assign tick_run  = (state_q == RUN) && frame_tick && !crash;
   assign spawn_now = tick_run && (cnt_q == CNT_LAST);

   // slots free before this tick; retirements this tick don't count
   assign free = ~valid;
   assign sel  = free & (~free + NUM_SLOTS'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear)         cnt_d = CNT_LAST;
      else if (spawn_now) cnt_d = '0;
      else if (tick_run)  cnt_d = cnt_q + CNT_W'(1);
   end

   assign score_d = |hit;
   assign drop_d  = spawn_now && (free == '0);

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      logic       v_q, v_d;
      logic [9:0] x_q, x_d;
      logic [8:0] g_q, g_d;
      logic       h;

      always_comb begin
         v_d = v_q;
         x_d = x_q;
         g_d = g_q;
         h   = 1'b0;
         if (clear) begin
            v_d = 1'b0;
         end else if (tick_run) begin
            if (v_q) begin
               if (x_q < X_SPEED) begin
                  v_d = 1'b0;
               end else begin
                  x_d = x_q - X_SPEED;
                  h   = (x_q >= X_BIRD) && (x_d < X_BIRD);
               end
            end else if (spawn_now && sel[i]) begin
               v_d = 1'b1;
               x_d = X_SPAWN;
               g_d = gap_new;
            end
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            v_q <= 1'b0;
            x_q <= X_SPAWN;
            g_q <= G_RESET;
         end else begin
            v_q <= v_d;
            x_q <= x_d;
            g_q <= g_d;
         end
      end

      assign valid[i]                = v_q;
      assign x_flat[10*i +: 10]      = x_q;
      assign gap_top_flat[9*i +: 9]  = g_q;
      assign hit[i]                  = h;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         score_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         score_q <= score_d;
         drop_q  <= drop_d;
      end
   end

   assign running     = (state_q == RUN);
   assign score_pulse = score_q;
   assign spawn_drop  = drop_q;

endmodule
